gray_accum_encoder: RTL and testbench
=====================================

// Module: gray_accum_encoder
// PURPOSE
//  Streaming Gray-code encoder: accepts binary sums (sum plus carry bit) from the Gray-adder datapath.
//  Accumulates one frame of beats modulo 2^(WIDTH+1) and returns the frame total Gray-encoded, with overflow and beat count.
//  Sits on the return path after the Gray-to-binary adder stage: that stage decodes Gray, this block re-encodes to Gray.
// PARAMETERS
//  WIDTH    4  operand width; bus and result are WIDTH+1 bits (sum plus carry)
//  COUNT_W  8  width of the per-frame beat counter
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          input beat valid
//  in_ready   out  1          block can accept a beat
//  in_bin     in   WIDTH+1    binary beat value, MSB is carry
//  in_last    in   1          final beat of frame (qualified by in_valid)
//  out_valid  out  1          result valid; held until accepted
//  out_ready  in   1          downstream accepts result
//  out_gray   out  WIDTH+1    Gray(frame total) = acc ^ (acc >> 1)
//  out_ovf    out  1          set if any addition in the frame wrapped past 2^(WIDTH+1)-1
//  out_count  out  COUNT_W    beats in the frame, saturating at 2^COUNT_W-1
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): state=ACCUM, acc=0, ovf=0, cnt=0.
//    Outputs after reset: out_valid=0, out_gray=0, out_ovf=0, out_count=0. in_ready=1.
//  - FSM states:
//    ACCUM: in_ready=1, out_valid=0.
//    EMIT:  in_ready=0, out_valid=1.
//  - Beat is accepted on in_valid & in_ready. On accept:
//    - acc <= (acc + in_bin) mod 2^(WIDTH+1).
//    - ovf <= ovf | carry-out of that add.
//    - cnt <= sat(cnt+1).
//  - Accepted beat with in_last=1:
//    - Registers out_gray = Gray(new acc), out_ovf = new ovf, out_count = new cnt.
//    - Goes to EMIT. out_valid rises the next cycle, so latency is 1 cycle from the last beat.
//    - acc/ovf/cnt clear in the same edge.
//  - EMIT: out_gray/out_ovf/out_count are stable while out_valid=1 and out_ready=0.
//  - out_valid & out_ready -> ACCUM.
//    - in_ready reasserts the cycle after.
//    - There is no combinational path out_ready->in_ready, so sustained throughput is one frame per (beats+1) cycles.
//  - In EMIT, in_valid is ignored and no beat is consumed.
//  - Single-beat frame (in_last on first beat): result = Gray(in_bin), count=1.
//  - in_bin=0 beats are counted normally.
//  - Counter saturates at 2^COUNT_W-1 and does not wrap. acc wraps silently; ovf is sticky per frame.
//  - out_gray holds its last value after handshake until the next frame result; only out_valid qualifies it.
//  - Reset asserted mid-frame or in EMIT:
//    - The partial frame and the pending result are discarded.
//    - Outputs go to reset values immediately.
//  - in_last with in_valid=0 has no effect. X on data is tolerated when in_valid=0.
// STRUCTURE
//  - Shared package gray_pkg:
//    - typedef enum logic {ACCUM, EMIT} gray_enc_state_t.
//    - functions bin2gray(x) and gray2bin(g), parameterised via WIDTH.
//    - constant GRAY_DEF_WIDTH=4.
//  - One combinational sub-module gray_encode #(N) (bin in, gray out). It is reused by future Gray-domain blocks.
//  - Top level holds the FSM, the accumulator with (WIDTH+2)-bit add for carry, the counter and the output registers.
// TESTING (WIDTH=4, COUNT_W=8)
//  1. Reset: rst_n=0 mid-frame after beats 5,7, then release, then frame {3}.
//     -> Outputs 0 during reset; result out_gray=00010, count=1, ovf=0 (partial frame lost).
//  2. Frame {3,4,5 last}: sum 12=01100.
//     -> out_gray=01010, ovf=0, count=3, out_valid one cycle after the last beat.
//  3. Frame {20,15 last}: 35 mod 32=3.
//     -> out_gray=00010, ovf=1, count=2.
//  4. Single beat {31 last}.
//     -> out_gray=10000, count=1, ovf=0.
//  5. Backpressure: out_ready=0 for 5 cycles with in_valid=1 and beat 9 presented.
//     -> Output stable, in_ready=0, beat 9 not consumed.
//     -> After handshake, beat 9 is accepted in the next frame.
//  6. 300-beat frame of 1s.
//     -> out_count=255 (saturated), out_gray=Gray(300 mod 32=12)=01010, ovf=1.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-domain definitions: FSM state type, default width and Gray conversions.
// The conversion functions work on zero-extended values up to GRAY_FN_W bits; callers truncate the result.
package gray_pkg;

  localparam int GRAY_DEF_WIDTH = 4;
  localparam int GRAY_FN_W      = 32;

  typedef enum logic {ACCUM, EMIT} gray_enc_state_t;

  function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] g);
    logic [GRAY_FN_W-1:0] b;
    b = g;
    for (int i = 1; i < GRAY_FN_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational N-bit binary-to-Gray encoder, shared by Gray-domain blocks.
module gray_encode
  import gray_pkg::*;
#(
  parameter int N = GRAY_DEF_WIDTH + 1
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  assign gray = N'(bin2gray(GRAY_FN_W'(bin)));

endmodule

// File: rtl/gray_accum_encoder.sv
// Accumulates a frame of binary beats modulo 2^(WIDTH+1) and emits the total Gray-encoded,
// together with a sticky overflow flag and a saturating beat count.
module gray_accum_encoder
  import gray_pkg::*;
#(
  parameter int WIDTH   = GRAY_DEF_WIDTH,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH:0]     in_bin,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_gray,
  output logic               out_ovf,
  output logic [COUNT_W-1:0] out_count
);

  localparam int BW = WIDTH + 1;

  gray_enc_state_t    state_q, state_d;
  logic [BW-1:0]      acc_p0;
  logic               ovf_p0;
  logic [COUNT_W-1:0] cnt_p0;

  logic               accept;
  logic [BW:0]        sum_p0;
  logic [BW-1:0]      acc_nxt;
  logic               carry;
  logic               ovf_nxt;
  logic [COUNT_W-1:0] cnt_nxt;
  logic [BW-1:0]      gray_nxt;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (&c) ? c : c + COUNT_W'(1);
  endfunction

  // Stage 0: one extra bit on the add exposes the wrap as a carry-out
  assign accept   = in_valid & in_ready;
  assign sum_p0   = {1'b0, acc_p0} + {1'b0, in_bin};
  assign acc_nxt  = sum_p0[BW-1:0];
  assign carry    = sum_p0[BW];
  assign ovf_nxt  = ovf_p0 | carry;
  assign cnt_nxt  = sat_inc(cnt_p0);

  gray_encode #(.N(BW)) u_gray_encode (
    .bin  (acc_nxt),
    .gray (gray_nxt)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage 1: the last beat of a frame loads the result registers and clears the running state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0    <= '0;
      ovf_p0    <= 1'b0;
      cnt_p0    <= '0;
      out_gray  <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (accept) begin
      if (in_last) begin
        acc_p0    <= '0;
        ovf_p0    <= 1'b0;
        cnt_p0    <= '0;
        out_gray  <= gray_nxt;
        out_ovf   <= ovf_nxt;
        out_count <= cnt_nxt;
      end else begin
        acc_p0 <= acc_nxt;
        ovf_p0 <= ovf_nxt;
        cnt_p0 <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gray_accum_encoder.sv
// Directed bench for gray_accum_encoder with WIDTH=4, COUNT_W=8.
module tb_gray_accum_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_bin;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_gray;
  logic       out_ovf;
  logic [7:0] out_count;

  int checks = 0;
  int errors = 0;

  gray_accum_encoder #(.WIDTH(4), .COUNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] v, input logic last);
    in_valid = 1'b1;
    in_bin   = v;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_bin   = 'x;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [4:0] g, input logic ovf,
                               input logic [7:0] cnt);
    check({tag, "_gray"}, {27'd0, out_gray}, {27'd0, g});
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
    check({tag, "_count"}, {24'd0, out_count}, {24'd0, cnt});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bin    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_gray", {27'd0, out_gray}, 32'd0);
    check("rst_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_count", {24'd0, out_count}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 1. partial frame {5,7} discarded by a mid-frame reset
    beat(5'd5, 1'b0);
    beat(5'd7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t1_rst_count", {24'd0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    beat(5'd3, 1'b1);
    wait_valid("t1_valid");
    expect_result("t1", 5'b00010, 1'b0, 8'd1);
    handshake("t1");
    check("t1_hold_gray", {27'd0, out_gray}, 32'b00010);

    // 2. {3,4,5}: sum 12, valid exactly one cycle after the last beat
    beat(5'd3, 1'b0);
    check("t2_novalid_b1", {31'd0, out_valid}, 32'd0);
    beat(5'd4, 1'b0);
    check("t2_novalid_b2", {31'd0, out_valid}, 32'd0);
    beat(5'd5, 1'b1);
    check("t2_latency", {31'd0, out_valid}, 32'd1);
    expect_result("t2", 5'b01010, 1'b0, 8'd3);
    handshake("t2");

    // 3. {20,15}: 35 wraps to 3
    beat(5'd20, 1'b0);
    beat(5'd15, 1'b1);
    wait_valid("t3_valid");
    expect_result("t3", 5'b00010, 1'b1, 8'd2);
    handshake("t3");

    // 4. single beat 31
    beat(5'd31, 1'b1);
    wait_valid("t4_valid");
    expect_result("t4", 5'b10000, 1'b0, 8'd1);
    handshake("t4");

    // 5. backpressure with beat 9 waiting
    beat(5'd1, 1'b1);
    wait_valid("t5_valid");
    in_valid = 1'b1;
    in_bin   = 5'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t5_bp_valid", {31'd0, out_valid}, 32'd1);
      check("t5_bp_ready", {31'd0, in_ready}, 32'd0);
      check("t5_bp_gray", {27'd0, out_gray}, 32'b00001);
      check("t5_bp_count", {24'd0, out_count}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_rdy_back", {31'd0, in_ready}, 32'd1);
    check("t5_vld_drop", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    in_bin   = 'x;
    in_last  = 1'b0;
    check("t5_next_valid", {31'd0, out_valid}, 32'd1);
    expect_result("t5_next", 5'b01101, 1'b0, 8'd1);
    handshake("t5");

    // 6. 300 beats of 1: count saturates, 300 mod 32 = 12
    for (int i = 0; i < 299; i++) beat(5'd1, 1'b0);
    check("t6_novalid", {31'd0, out_valid}, 32'd0);
    beat(5'd1, 1'b1);
    wait_valid("t6_valid");
    expect_result("t6", 5'b01010, 1'b1, 8'd255);
    handshake("t6");

    // reset while a result is pending drops it
    beat(5'd6, 1'b1);
    wait_valid("t7_valid");
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t7_rst_gray", {27'd0, out_gray}, 32'd0);
    check("t7_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
